// File: rtl/bridge_reg_bank.sv
// Bank of NUM_REGS 32-bit configuration registers on the APF bridge with per-bit write masks,
// optional shadow buffering with atomic commit/discard, registered read data and change pulses.
module bridge_reg_bank #(
    parameter logic [31:0]            BASE_ADDR    = 32'h0010_0000,
    parameter int                     NUM_REGS     = 4,
    parameter logic [NUM_REGS*32-1:0] RESET_VALUES = '0,
    parameter logic [NUM_REGS*32-1:0] WRITE_MASKS  = '1,
    parameter logic [NUM_REGS-1:0]    SHADOWED     = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              bridge_addr,
    input  logic                     bridge_wr,
    input  logic [31:0]              bridge_wr_data,
    input  logic                     bridge_rd,
    output logic [31:0]              bridge_rd_data,
    output logic                     selected,
    input  logic                     apply_strobe,
    output logic [NUM_REGS*32-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      changed,
    output logic [NUM_REGS-1:0]      pending
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [31:0]         offset;
    logic [31:0]         word_idx;
    logic [IW-1:0]       reg_idx;
    logic                hit;
    logic                data_hit;
    logic                ctrl_hit;
    logic                ctrl_wr;
    logic                commit;
    logic                discard;

    logic [31:0]         active_q [NUM_REGS];
    logic [31:0]         active_d [NUM_REGS];
    logic [31:0]         shadow_q [NUM_REGS];
    logic [31:0]         shadow_d [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] changed_q, changed_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                selected_q;

    // The strobe only qualifies reads upstream; read data here is produced every cycle.
    logic unused_rd;
    assign unused_rd = bridge_rd;

    // Unsigned wrap-around makes addresses below BASE_ADDR land far out of range.
    assign offset   = bridge_addr - BASE_ADDR;
    assign word_idx = {2'b00, offset[31:2]};
    assign hit      = (offset[1:0] == 2'b00) && (word_idx <= 32'(NUM_REGS));
    assign data_hit = hit && (word_idx <  32'(NUM_REGS));
    assign ctrl_hit = hit && (word_idx == 32'(NUM_REGS));
    assign reg_idx  = word_idx[IW-1:0];

    assign ctrl_wr  = bridge_wr && ctrl_hit;
    assign commit   = apply_strobe || (ctrl_wr && bridge_wr_data[0]);
    assign discard  = ctrl_wr && bridge_wr_data[1] && !commit;

    function automatic logic [31:0] masked_value(input int idx, input logic [31:0] data);
        return (data & WRITE_MASKS[32*idx +: 32]) |
               (RESET_VALUES[32*idx +: 32] & ~WRITE_MASKS[32*idx +: 32]);
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        changed_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (SHADOWED[i]) begin
                // Commit and discard act on the old shadow; a same-cycle write then re-arms pending.
                if (commit && pending_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end else if (discard && pending_q[i]) begin
                    shadow_d[i]  = active_q[i];
                    pending_d[i] = 1'b0;
                end
                if (bridge_wr && data_hit && (reg_idx == IW'(i))) begin
                    shadow_d[i]  = masked_value(i, bridge_wr_data);
                    pending_d[i] = 1'b1;
                end
            end else if (bridge_wr && data_hit && (reg_idx == IW'(i))) begin
                active_d[i] = masked_value(i, bridge_wr_data);
            end
            changed_d[i] = (active_d[i] != active_q[i]);
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (data_hit) begin
            rd_data_d = SHADOWED[reg_idx] ? shadow_q[reg_idx] : active_q[reg_idx];
        end else if (ctrl_hit) begin
            rd_data_d = 32'(pending_q);
        end
    end

    // NOTE: the register arrays are flip-flops holding architectural state, not RAM, so they are
    // reset along with everything else; a RAM would be left without reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                active_q[i] <= RESET_VALUES[32*i +: 32];
                shadow_q[i] <= RESET_VALUES[32*i +: 32];
            end
            pending_q  <= '0;
            changed_q  <= '0;
            rd_data_q  <= '0;
            selected_q <= 1'b0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            changed_q  <= changed_d;
            rd_data_q  <= rd_data_d;
            selected_q <= hit;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[32*g +: 32] = active_q[g];
    end

    assign changed        = changed_q;
    assign pending        = pending_q;
    assign bridge_rd_data = rd_data_q;
    assign selected       = selected_q;

endmodule

// File: tb/tb_bridge_reg_bank.sv
// Self-checking bench for bridge_reg_bank: table of single-cycle vectors with a scoreboard queue,
// plus a hand-written asynchronous-reset sequence.
module tb_bridge_reg_bank;

    localparam logic [31:0]  B  = 32'h0010_0000;
    localparam int           N  = 4;
    localparam logic [127:0] RV = {32'h3, 32'hA, 32'h5, 32'h0};
    localparam logic [127:0] WM = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    localparam logic [3:0]   SH = 4'b0010;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [31:0]   bridge_addr;
    logic          bridge_wr;
    logic [31:0]   bridge_wr_data;
    logic          bridge_rd;
    logic [31:0]   bridge_rd_data;
    logic          selected;
    logic          apply_strobe;
    logic [127:0]  regs_out;
    logic [3:0]    changed;
    logic [3:0]    pending;

    bridge_reg_bank #(
        .BASE_ADDR   (B),
        .NUM_REGS    (N),
        .RESET_VALUES(RV),
        .WRITE_MASKS (WM),
        .SHADOWED    (SH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bridge_addr   (bridge_addr),
        .bridge_wr     (bridge_wr),
        .bridge_wr_data(bridge_wr_data),
        .bridge_rd     (bridge_rd),
        .bridge_rd_data(bridge_rd_data),
        .selected      (selected),
        .apply_strobe  (apply_strobe),
        .regs_out      (regs_out),
        .changed       (changed),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [31:0]  wdata;
        logic         apply;
        logic [31:0]  exp_rd;
        logic         exp_sel;
        logic [3:0]   exp_chg;
        logic [3:0]   exp_pend;
        logic [127:0] exp_regs;
    } vec_t;

    typedef struct {
        string        name;
        logic [31:0]  rd;
        logic         sel;
        logic [3:0]   chg;
        logic [3:0]   pend;
        logic [127:0] regs;
    } exp_t;

    vec_t vecs[20];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] r4(input logic [31:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic vec_t mk(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                                input logic apply, input logic [31:0] rd, input logic sel,
                                input logic [3:0] chg, input logic [3:0] pend,
                                input logic [127:0] regs);
        vec_t v;
        v.addr = addr; v.wr = wr; v.wdata = wdata; v.apply = apply;
        v.exp_rd = rd; v.exp_sel = sel; v.exp_chg = chg; v.exp_pend = pend; v.exp_regs = regs;
        return v;
    endfunction

    task automatic idle_inputs();
        bridge_addr    = 32'h0;
        bridge_wr      = 1'b0;
        bridge_wr_data = 32'h0;
        bridge_rd      = 1'b0;
        apply_strobe   = 1'b0;
    endtask

    // Drive on the falling edge, let the rising edge capture, compare 1 time unit later.
    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        bridge_addr    = v.addr;
        bridge_wr      = v.wr;
        bridge_wr_data = v.wdata;
        bridge_rd      = !v.wr;
        apply_strobe   = v.apply;
        e.name = name; e.rd = v.exp_rd; e.sel = v.exp_sel;
        e.chg = v.exp_chg; e.pend = v.exp_pend; e.regs = v.exp_regs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 128'd0, 128'd1);
        end else begin
            e = sb.pop_front();
            check({e.name, " rd_data"},  128'(bridge_rd_data), 128'(e.rd));
            check({e.name, " selected"}, 128'(selected),       128'(e.sel));
            check({e.name, " changed"},  128'(changed),        128'(e.chg));
            check({e.name, " pending"},  128'(pending),        128'(e.pend));
            check({e.name, " regs_out"}, regs_out,             e.regs);
        end
    endtask

    initial begin
        vecs[0]  = mk(B+32'h8,  0, 32'h0,         0, 32'hA,    1, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h5, 32'h0));
        vecs[1]  = mk(B+32'h0,  1, 32'hFFFF_FFFF, 0, 32'h0,    1, 4'h1, 4'h0, r4(32'h3, 32'hA, 32'h5, 32'hFF));
        vecs[2]  = mk(B+32'h0,  1, 32'hFFFF_FFFF, 0, 32'hFF,   1, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h5, 32'hFF));
        vecs[3]  = mk(B+32'h4,  1, 32'h1234,      0, 32'h5,    1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h5, 32'hFF));
        vecs[4]  = mk(B+32'h10, 0, 32'h0,         0, 32'h2,    1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h5, 32'hFF));
        vecs[5]  = mk(B+32'h4,  0, 32'h0,         1, 32'h1234, 1, 4'h2, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[6]  = mk(B+32'h4,  1, 32'h1234,      0, 32'h1234, 1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[7]  = mk(B+32'h4,  1, 32'h55,        1, 32'h1234, 1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[8]  = mk(B+32'h10, 0, 32'h0,         0, 32'h2,    1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[9]  = mk(B+32'h4,  0, 32'h0,         0, 32'h55,   1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[10] = mk(B+32'h10, 1, 32'h2,         0, 32'h2,    1, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[11] = mk(B+32'h4,  0, 32'h0,         0, 32'h1234, 1, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[12] = mk(B+32'h2,  1, 32'hDEAD_BEEF, 0, 32'h0,    0, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[13] = mk(B+32'h14, 1, 32'hDEAD_BEEF, 0, 32'h0,    0, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[14] = mk(B-32'h4,  1, 32'hDEAD_BEEF, 0, 32'h0,    0, 4'h0, 4'h0, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[15] = mk(B+32'h4,  1, 32'hCAFE,      0, 32'h1234, 1, 4'h0, 4'h2, r4(32'h3, 32'hA, 32'h1234, 32'hFF));
        vecs[16] = mk(B+32'h10, 1, 32'h3,         0, 32'h2,    1, 4'h2, 4'h0, r4(32'h3, 32'hA, 32'hCAFE, 32'hFF));
        vecs[17] = mk(B+32'hC,  1, 32'h99,        0, 32'h3,    1, 4'h8, 4'h0, r4(32'h99, 32'hA, 32'hCAFE, 32'hFF));
        vecs[18] = mk(B+32'h10, 0, 32'h0,         0, 32'h0,    1, 4'h0, 4'h0, r4(32'h99, 32'hA, 32'hCAFE, 32'hFF));
        vecs[19] = mk(B+32'h4,  1, 32'h42,        0, 32'hCAFE, 1, 4'h0, 4'h2, r4(32'h99, 32'hA, 32'hCAFE, 32'hFF));

        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("reset regs_out", regs_out,                RV);
        check("reset pending",  128'(pending),           128'd0);
        check("reset changed",  128'(changed),           128'd0);
        check("reset rd_data",  128'(bridge_rd_data),    128'd0);
        check("reset selected", 128'(selected),          128'd0);

        for (int i = 0; i < 20; i++) begin
            run_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset mid-sequence with pending set and a commit being requested.
        @(negedge clk);
        idle_inputs();
        bridge_addr  = B + 32'h4;
        apply_strobe = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        check("async rst regs_out", regs_out,             RV);
        check("async rst pending",  128'(pending),        128'd0);
        check("async rst changed",  128'(changed),        128'd0);
        check("async rst rd_data",  128'(bridge_rd_data), 128'd0);
        check("async rst selected", 128'(selected),       128'd0);
        @(posedge clk);
        #1;
        check("held rst regs_out", regs_out, RV);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b1;

        run_vec("post-rst shadow", mk(B+32'h4,  0, 32'h0, 0, 32'h5, 1, 4'h0, 4'h0, RV));
        run_vec("post-rst ctrl",   mk(B+32'h10, 0, 32'h0, 0, 32'h0, 1, 4'h0, 4'h0, RV));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
